// File: rtl/reservation_station_pkg.sv
// Shared opcode encodings, station entry layout and the broadcast snoop helper.
package reservation_station_pkg;

  localparam int TAG_W = 3;

  localparam logic [4:0] ADD   = 5'h00;
  localparam logic [4:0] SUB   = 5'h01;
  localparam logic [4:0] SLL   = 5'h02;
  localparam logic [4:0] SLT   = 5'h03;
  localparam logic [4:0] SLTU  = 5'h04;
  localparam logic [4:0] XOR   = 5'h05;
  localparam logic [4:0] SRL   = 5'h06;
  localparam logic [4:0] SRA   = 5'h07;
  localparam logic [4:0] OR    = 5'h08;
  localparam logic [4:0] AND   = 5'h09;
  localparam logic [4:0] BEQ   = 5'h0a;
  localparam logic [4:0] BNE   = 5'h0b;
  localparam logic [4:0] BLT   = 5'h0c;
  localparam logic [4:0] BGE   = 5'h0d;
  localparam logic [4:0] BLTU  = 5'h0e;
  localparam logic [4:0] BGEU  = 5'h0f;
  localparam logic [4:0] JALR  = 5'h10;
  localparam logic [4:0] LUI   = 5'h11;
  localparam logic [4:0] LB    = 5'h12;
  localparam logic [4:0] LH    = 5'h13;
  localparam logic [4:0] LW    = 5'h14;
  localparam logic [4:0] LBU   = 5'h15;
  localparam logic [4:0] LHU   = 5'h16;
  localparam logic [4:0] SB    = 5'h17;
  localparam logic [4:0] SH    = 5'h18;
  localparam logic [4:0] SW    = 5'h19;
  localparam logic [4:0] AUIPC = 5'h1a;
  localparam logic [4:0] JAL   = 5'h1b;
  localparam logic [4:0] JAL_C = 5'h1c;
  localparam logic [4:0] NOP   = 5'h1f;

  typedef struct packed {
    logic             valid;
    logic [4:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             br;
  } rs_entry_t;

  // Returns {q, v}; ALU broadcast wins over memory when both carry the awaited tag.
  function automatic logic [TAG_W+31:0] snoop(
    input logic [TAG_W-1:0] q,     input logic [31:0] v,
    input logic [TAG_W-1:0] a_num, input logic [31:0] a_val,
    input logic [TAG_W-1:0] m_num, input logic [31:0] m_val);
    if (q != '0 && q == a_num)      return {{TAG_W{1'b0}}, a_val};
    else if (q != '0 && q == m_num) return {{TAG_W{1'b0}}, m_val};
    else                            return {q, v};
  endfunction

endpackage

// File: rtl/reservation_station_if.sv
// ROB issue side, memory broadcast and ALU result bus of the reservation station.
interface reservation_station_if;
  import reservation_station_pkg::*;

  logic             flush;
  logic [4:0]       op_in;
  logic [31:0]      value1_in;
  logic [31:0]      value2_in;
  logic [TAG_W-1:0] query1_in;
  logic [TAG_W-1:0] query2_in;
  logic [31:0]      imm_in;
  logic [TAG_W-1:0] target_in;
  logic             is_branch_in;
  logic [TAG_W-1:0] mem_num;
  logic [31:0]      mem_value;
  logic             rs_full;
  logic [TAG_W-1:0] alu_num;
  logic [31:0]      alu_value;
  logic             is_branch;

  modport master (
    output flush, op_in, value1_in, value2_in, query1_in, query2_in, imm_in,
           target_in, is_branch_in, mem_num, mem_value,
    input  rs_full, alu_num, alu_value, is_branch
  );

  modport slave (
    input  flush, op_in, value1_in, value2_in, query1_in, query2_in, imm_in,
           target_in, is_branch_in, mem_num, mem_value,
    output rs_full, alu_num, alu_value, is_branch
  );
endinterface

// File: rtl/reservation_station_alu.sv
// rs_alu: purely combinational integer/branch/JALR evaluation for one op.
module rs_alu
  import reservation_station_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm,
  output logic [31:0] value
);
  always_comb begin
    value = '0;
    case (op)
      ADD:  value = a + b;
      SUB:  value = a - b;
      SLL:  value = a << b[4:0];
      SLT:  value = {31'b0, $signed(a) < $signed(b)};
      SLTU: value = {31'b0, a < b};
      XOR:  value = a ^ b;
      SRL:  value = a >> b[4:0];
      SRA:  value = $signed(a) >>> b[4:0];
      OR:   value = a | b;
      AND:  value = a & b;
      BEQ:  value = {31'b0, a == b};
      BNE:  value = {31'b0, a != b};
      BLT:  value = {31'b0, $signed(a) < $signed(b)};
      BGE:  value = {31'b0, $signed(a) >= $signed(b)};
      BLTU: value = {31'b0, a < b};
      BGEU: value = {31'b0, a >= b};
      JALR: value = (a + imm) & ~32'd1;
      default: value = '0;
    endcase
  end
endmodule

// File: rtl/reservation_station.sv
// Reservation station: buffers ALU/branch/JALR ops, wakes operands, issues one per cycle.
// Build option RS_OLDEST_FIRST_EN: select the oldest ready entry instead of the lowest index.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  reservation_station_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  rs_entry_t        ent_q [DEPTH];
  rs_entry_t        ent_d [DEPTH];
  rs_entry_t        sel_ent;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             free_found, sel_found, issue_ok, rs_full_d;
  logic [31:0]      alu_res;
  int               n_valid;

  logic [TAG_W-1:0] alu_num_q;
  logic [31:0]      alu_value_q;
  logic             is_branch_q, rs_full_q;

`ifdef RS_OLDEST_FIRST_EN
  logic [2:0] age_q [DEPTH];
  logic [2:0] best_age;
`endif

  assign issue_ok = (bus.op_in != NOP) && !(bus.op_in >= LB && bus.op_in <= SW);

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
`ifdef RS_OLDEST_FIRST_EN
    best_age   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
`ifdef RS_OLDEST_FIRST_EN
      if (ent_q[i].valid && ent_q[i].qj == '0 && ent_q[i].qk == '0 &&
          (!sel_found || age_q[i] > best_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age_q[i];
      end
`else
      if (ent_q[i].valid && ent_q[i].qj == '0 && ent_q[i].qk == '0 && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
`endif
    end
  end

  assign sel_ent = ent_q[sel_idx];

  rs_alu u_alu (
    .op    (sel_ent.op),
    .a     (sel_ent.vj),
    .b     (sel_ent.vk),
    .imm   (sel_ent.imm),
    .value (alu_res)
  );

  // Entries are selected from pre-edge state, so a wakeup or issue this edge executes next cycle.
  always_comb begin
    n_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        {ent_d[i].qj, ent_d[i].vj} = snoop(ent_q[i].qj, ent_q[i].vj, alu_num_q, alu_value_q,
                                           bus.mem_num, bus.mem_value);
        {ent_d[i].qk, ent_d[i].vk} = snoop(ent_q[i].qk, ent_q[i].vk, alu_num_q, alu_value_q,
                                           bus.mem_num, bus.mem_value);
      end
    end
    if (sel_found) ent_d[sel_idx].valid = 1'b0;
    if (issue_ok && free_found) begin
      ent_d[free_idx].valid = 1'b1;
      ent_d[free_idx].op    = bus.op_in;
      {ent_d[free_idx].qj, ent_d[free_idx].vj} = snoop(bus.query1_in, bus.value1_in, alu_num_q,
                                                       alu_value_q, bus.mem_num, bus.mem_value);
      {ent_d[free_idx].qk, ent_d[free_idx].vk} = snoop(bus.query2_in, bus.value2_in, alu_num_q,
                                                       alu_value_q, bus.mem_num, bus.mem_value);
      ent_d[free_idx].imm   = bus.imm_in;
      ent_d[free_idx].tag   = bus.target_in;
      ent_d[free_idx].br    = bus.is_branch_in;
    end
    for (int i = 0; i < DEPTH; i++) n_valid = n_valid + int'(ent_d[i].valid);
    rs_full_d = (DEPTH - n_valid) <= 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      alu_num_q   <= '0;
      alu_value_q <= '0;
      is_branch_q <= 1'b0;
      rs_full_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      rs_full_q <= rs_full_d;
      if (sel_found) begin
        alu_num_q   <= sel_ent.tag;
        alu_value_q <= alu_res;
        is_branch_q <= sel_ent.br;
      end else begin
        alu_num_q   <= '0;
        alu_value_q <= '0;
        is_branch_q <= 1'b0;
      end
    end
  end

`ifdef RS_OLDEST_FIRST_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n || bus.flush || (issue_ok && free_found && free_idx == IDX_W'(i)))
        age_q[i] <= '0;
      else if (ent_q[i].valid && age_q[i] != 3'd7)
        age_q[i] <= age_q[i] + 3'd1;
    end
  end
`endif

  assign bus.alu_num   = alu_num_q;
  assign bus.alu_value = alu_value_q;
  assign bus.is_branch = is_branch_q;
  assign bus.rs_full   = rs_full_q;
endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (default DEPTH=4).
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  reservation_station_if bus ();

  reservation_station #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush        = 1'b0;
    bus.op_in        = NOP;
    bus.value1_in    = '0;
    bus.value2_in    = '0;
    bus.query1_in    = '0;
    bus.query2_in    = '0;
    bus.imm_in       = '0;
    bus.target_in    = '0;
    bus.is_branch_in = 1'b0;
    bus.mem_num      = '0;
    bus.mem_value    = '0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [2:0] q1, input logic [2:0] q2, input logic [31:0] imm,
                       input logic [2:0] tgt, input logic br);
    bus.op_in        = op;
    bus.value1_in    = v1;
    bus.value2_in    = v2;
    bus.query1_in    = q1;
    bus.query2_in    = q2;
    bus.imm_in       = imm;
    bus.target_in    = tgt;
    bus.is_branch_in = br;
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic br,
                        input logic [2:0] tgt, input logic [31:0] exp_val);
    drive(op, a, b, 3'd0, 3'd0, imm, tgt, br);
    step();
    idle();
    step();
    check({name, "_num"}, 32'(bus.alu_num), 32'(tgt));
    check({name, "_val"}, bus.alu_value, exp_val);
    check({name, "_br"},  32'(bus.is_branch), 32'(br));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    drive(ADD, 32'd1, 32'd1, 3'd0, 3'd0, 32'd0, 3'd1, 1'b0);
    step();
    step();
    check("rst_num",  32'(bus.alu_num), 32'd0);
    check("rst_full", 32'(bus.rs_full), 32'd0);
    check("rst_val",  bus.alu_value, 32'd0);
    rst_n = 1'b1;
    idle();
    step();
    check("rst_retain_num", 32'(bus.alu_num), 32'd0);
    step();
    check("rst_retain_num2", 32'(bus.alu_num), 32'd0);

    // Ready ADD: one edge to enter, next edge produces the result.
    drive(ADD, 32'd5, 32'd7, 3'd0, 3'd0, 32'd0, 3'd3, 1'b0);
    step();
    idle();
    check("add_lat_num", 32'(bus.alu_num), 32'd0);
    step();
    check("add_num", 32'(bus.alu_num), 32'd3);
    check("add_val", bus.alu_value, 32'd12);
    check("add_br",  32'(bus.is_branch), 32'd0);

    // Dependency woken by the memory broadcast.
    drive(SUB, 32'd0, 32'd1, 3'd4, 3'd0, 32'd0, 3'd5, 1'b0);
    step();
    idle();
    step();
    check("dep_wait_num", 32'(bus.alu_num), 32'd0);
    bus.mem_num   = 3'd4;
    bus.mem_value = 32'd10;
    step();
    idle();
    check("dep_wake_num", 32'(bus.alu_num), 32'd0);
    step();
    check("dep_num", 32'(bus.alu_num), 32'd5);
    check("dep_val", bus.alu_value, 32'd9);

    // Issue-time bypass from alu_num; mem_num carries the same tag and must lose.
    drive(ADD, 32'hF0, 32'h0, 3'd0, 3'd0, 32'd0, 3'd2, 1'b0);
    step();
    idle();
    step();
    check("byp_src_num", 32'(bus.alu_num), 32'd2);
    check("byp_src_val", bus.alu_value, 32'hF0);
    drive(AND, 32'd0, 32'h3C, 3'd2, 3'd0, 32'd0, 3'd6, 1'b0);
    bus.mem_num   = 3'd2;
    bus.mem_value = 32'hFF;
    step();
    idle();
    check("byp_lat_num", 32'(bus.alu_num), 32'd0);
    step();
    check("byp_num", 32'(bus.alu_num), 32'd6);
    check("byp_val", bus.alu_value, 32'h30);

    // Issue-time bypass from mem_num on the second operand.
    drive(OR, 32'hF0, 32'd0, 3'd0, 3'd7, 32'd0, 3'd1, 1'b0);
    bus.mem_num   = 3'd7;
    bus.mem_value = 32'h0F;
    step();
    idle();
    step();
    check("mbyp_num", 32'(bus.alu_num), 32'd1);
    check("mbyp_val", bus.alu_value, 32'hFF);

    run_op("blt",  BLT,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3'd2, 32'd1);
    run_op("bltu", BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3'd3, 32'd0);
    run_op("bge",  BGE,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 3'd4, 32'd0);
    run_op("jalr", JALR, 32'h101, 32'd0, 32'd4, 1'b0, 3'd5, 32'h104);
    run_op("sra",  SRA,  32'h8000_0000, 32'h21, 32'd0, 1'b0, 3'd6, 32'hC000_0000);
    run_op("sll",  SLL,  32'd1, 32'd33, 32'd0, 1'b0, 3'd1, 32'd2);
    run_op("sub_wrap", SUB, 32'd0, 32'd1, 32'd0, 1'b0, 3'd2, 32'hFFFF_FFFF);
    run_op("sltu", SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'd3, 32'd1);
    run_op("slt",  SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 3'd4, 32'd0);

    // Loads/stores are not accepted.
    drive(LW, 32'd1, 32'd2, 3'd0, 3'd0, 32'd0, 3'd5, 1'b0);
    step();
    idle();
    step();
    check("load_ignored", 32'(bus.alu_num), 32'd0);

    // Fill with blocked ops; rs_full rises once at most one slot remains.
    for (int k = 0; k < 4; k++) begin
      drive(ADD, 32'd0, 32'd1, 3'd7, 3'd0, 32'd0, 3'(k + 1), 1'b0);
      step();
      check($sformatf("fill%0d_full", k), 32'(bus.rs_full), (k >= 2) ? 32'd1 : 32'd0);
    end
    drive(ADD, 32'd2, 32'd3, 3'd0, 3'd0, 32'd0, 3'd5, 1'b0);
    step();
    check("full_drop_num", 32'(bus.alu_num), 32'd0);
    check("full_still",    32'(bus.rs_full), 32'd1);

    drive(ADD, 32'd2, 32'd3, 3'd0, 3'd0, 32'd0, 3'd6, 1'b0);
    bus.flush = 1'b1;
    step();
    check("flush_full", 32'(bus.rs_full), 32'd0);
    check("flush_num",  32'(bus.alu_num), 32'd0);
    idle();
    bus.mem_num   = 3'd7;
    bus.mem_value = 32'h55;
    step();
    check("flush_issue_dropped", 32'(bus.alu_num), 32'd0);
    idle();
    step();
    check("flush_no_wake", 32'(bus.alu_num), 32'd0);
    step();
    check("flush_no_wake2", 32'(bus.alu_num), 32'd0);

    run_op("post_flush", XOR, 32'hFF00, 32'h0FF0, 32'd0, 1'b0, 3'd3, 32'hF0F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
